// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths and the 3-bit state encodings
// used by the receiver, transmitter and the UART/ALU bridge.
package uart_pkg;

  localparam int DBIT_DEF  = 8;
  localparam int NB_OP_DEF = 6;

  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;

  typedef enum logic [2:0] {
    WAIT_A  = ST_WAIT_A,
    WAIT_B  = ST_WAIT_B,
    WAIT_OP = ST_WAIT_OP,
    EXEC    = ST_EXEC,
    WAIT_TX = ST_WAIT_TX
  } alu_intf_state_t;

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte timeout counter: counts while enabled, holds once expired,
// and reports expiry only while enabled.
module uart_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == LAST);
  assign expired = en && at_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_last) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_alu_intf.sv
// Bridges a UART byte stream to a combinational ALU: collects A, B and opcode,
// sends the result back through the transmitter, and flags timeouts/overruns.
module uart_alu_intf
  import uart_pkg::*;
#(
  parameter int DBIT        = DBIT_DEF,
  parameter int NB_OP       = NB_OP_DEF,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_done_tick,
  input  logic [DBIT-1:0]  rx_data,
  output logic [DBIT-1:0]  alu_a,
  output logic [DBIT-1:0]  alu_b,
  output logic [NB_OP-1:0] alu_op,
  input  logic [DBIT-1:0]  alu_result,
  output logic             tx_start,
  output logic [DBIT-1:0]  tx_data,
  input  logic             tx_done_tick,
  output logic             frame_err,
  output logic             overrun
);

  alu_intf_state_t  state, state_nxt;
  logic [DBIT-1:0]  a_nxt, b_nxt, tx_data_nxt;
  logic [NB_OP-1:0] op_nxt;
  logic             tx_start_nxt, overrun_nxt;
  logic             tmr_clr, tmr_en, tmr_expired;

  uart_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= WAIT_A;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      alu_a    <= a_nxt;
      alu_b    <= b_nxt;
      alu_op   <= op_nxt;
      tx_data  <= tx_data_nxt;
      tx_start <= tx_start_nxt;
      overrun  <= overrun_nxt;
    end
  end

  // Timer is held clear outside WAIT_B/WAIT_OP, so every entry starts from zero.
  always_comb begin
    state_nxt    = state;
    a_nxt        = alu_a;
    b_nxt        = alu_b;
    op_nxt       = alu_op;
    tx_data_nxt  = tx_data;
    tx_start_nxt = 1'b0;
    overrun_nxt  = 1'b0;
    frame_err    = 1'b0;
    tmr_clr      = 1'b1;
    tmr_en       = 1'b0;
    case (state)
      WAIT_A: begin
        if (rx_done_tick) begin
          a_nxt     = rx_data;
          state_nxt = WAIT_B;
        end
      end
      WAIT_B: begin
        tmr_en  = 1'b1;
        tmr_clr = 1'b0;
        if (rx_done_tick) begin
          b_nxt     = rx_data;
          state_nxt = WAIT_OP;
          tmr_clr   = 1'b1;
        end else if (tmr_expired) begin
          state_nxt = WAIT_A;
          frame_err = 1'b1;
        end
      end
      WAIT_OP: begin
        tmr_en  = 1'b1;
        tmr_clr = 1'b0;
        if (rx_done_tick) begin
          op_nxt    = rx_data[NB_OP-1:0];
          state_nxt = EXEC;
        end else if (tmr_expired) begin
          state_nxt = WAIT_A;
          frame_err = 1'b1;
        end
      end
      EXEC: begin
        tx_data_nxt  = alu_result;
        tx_start_nxt = 1'b1;
        overrun_nxt  = rx_done_tick;
        state_nxt    = WAIT_TX;
      end
      WAIT_TX: begin
        overrun_nxt = rx_done_tick;
        if (tx_done_tick) state_nxt = WAIT_A;
      end
      default: state_nxt = WAIT_A;
    endcase
  end

endmodule
